// File: rtl/draw_cursor_if.sv
// ============================================================================
// Module  : vga_if
// Brief   : VGA timing plus 12-bit RGB pixel stream between draw stages.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport master (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport slave  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

`default_nettype wire

// File: rtl/draw_cursor.sv
// ============================================================================
// Module  : draw_cursor
// Brief   : Board cursor tracking, 2-click pick/place FSM and outline overlay.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module draw_cursor #(
  parameter int          BOARD_X      = 83,
  parameter int          BOARD_Y      = 180,
  parameter int          SQ           = 45,
  parameter int          N            = 9,
  parameter int          BORDER       = 3,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] CURSOR_COLOR = 12'h0F0,
  parameter logic [11:0] PICK_COLOR   = 12'hF00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_up,
  input  logic       move_down,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       sel,
  vga_if.slave       vga_in,
  vga_if.master      vga_out,
  output logic [3:0] cur_col,
  output logic [3:0] cur_row,
  output logic       move_valid,
  output logic [3:0] from_col,
  output logic [3:0] from_row,
  output logic [3:0] to_col,
  output logic [3:0] to_row
);

  localparam int          CW        = $clog2(BLINK_FRAMES + 1);
  localparam logic [3:0]  c_max     = 4'(N - 1);
  localparam logic [10:0] c_bx      = 11'(BOARD_X);
  localparam logic [10:0] c_by      = 11'(BOARD_Y);
  localparam logic [10:0] c_bx_end  = 11'(BOARD_X + N * SQ);
  localparam logic [10:0] c_by_end  = 11'(BOARD_Y + N * SQ);
  localparam logic [10:0] c_bd_lo   = 11'(BORDER);
  localparam logic [10:0] c_bd_hi   = 11'(SQ - BORDER);
  localparam logic [CW-1:0] c_blink_last = CW'(BLINK_FRAMES - 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_PICKED = 1'b1;

  logic [0:0]    r_state;
  logic [CW-1:0] r_blink_cnt;
  logic          r_phase;
  logic          r_draw_phase;
  logic          r_draw_picked;
  logic [3:0]    r_draw_col, r_draw_row, r_draw_fcol, r_draw_frow;
  logic          w_frame_start;

  assign w_frame_start = (vga_in.vcount == 11'd0) && (vga_in.hcount == 11'd0);

  // sel is evaluated against the cursor before any same-cycle move lands
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_col    <= 4'd4;
      cur_row    <= 4'd4;
      r_state    <= S_IDLE;
      move_valid <= 1'b0;
      from_col   <= 4'd0;
      from_row   <= 4'd0;
      to_col     <= 4'd0;
      to_row     <= 4'd0;
    end else begin
      move_valid <= 1'b0;
      if (sel) begin
        if (r_state == S_IDLE) begin
          r_state  <= S_PICKED;
          from_col <= cur_col;
          from_row <= cur_row;
        end else begin
          r_state <= S_IDLE;
          if ((cur_col != from_col) || (cur_row != from_row)) begin
            to_col     <= cur_col;
            to_row     <= cur_row;
            move_valid <= 1'b1;
          end
        end
      end
      if (move_up) begin
        if (cur_row != 4'd0) cur_row <= cur_row - 4'd1;
      end else if (move_down) begin
        if (cur_row != c_max) cur_row <= cur_row + 4'd1;
      end else if (move_left) begin
        if (cur_col != 4'd0) cur_col <= cur_col - 4'd1;
      end else if (move_right) begin
        if (cur_col != c_max) cur_col <= cur_col + 4'd1;
      end
    end
  end

  // Draw copies only change at frame start so an outline never tears mid-frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_phase       <= 1'b1;
      r_draw_phase  <= 1'b1;
      r_draw_picked <= 1'b0;
      r_draw_col    <= 4'd4;
      r_draw_row    <= 4'd4;
      r_draw_fcol   <= 4'd0;
      r_draw_frow   <= 4'd0;
    end else if (w_frame_start) begin
      r_draw_phase  <= r_phase;
      r_draw_picked <= (r_state == S_PICKED);
      r_draw_col    <= cur_col;
      r_draw_row    <= cur_row;
      r_draw_fcol   <= from_col;
      r_draw_frow   <= from_row;
      if (r_blink_cnt == c_blink_last) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + CW'(1);
      end
    end
  end

  logic [10:0] w_x_rel, w_y_rel, w_x_off, w_y_off;
  logic [3:0]  w_col, w_row;
  logic        w_on_board, w_border;

  assign w_x_rel = vga_in.hcount - c_bx;
  assign w_y_rel = vga_in.vcount - c_by;

  // Constant-step compare chain stands in for a divide by the square size
  always_comb begin
    w_col   = 4'd0;
    w_row   = 4'd0;
    w_x_off = w_x_rel;
    w_y_off = w_y_rel;
    for (int k = 1; k < N; k++) begin
      if (w_x_rel >= 11'(k * SQ)) begin
        w_col   = 4'(k);
        w_x_off = w_x_rel - 11'(k * SQ);
      end
      if (w_y_rel >= 11'(k * SQ)) begin
        w_row   = 4'(k);
        w_y_off = w_y_rel - 11'(k * SQ);
      end
    end
  end

  assign w_on_board = (vga_in.hcount >= c_bx) && (vga_in.hcount < c_bx_end) &&
                      (vga_in.vcount >= c_by) && (vga_in.vcount < c_by_end);
  assign w_border   = (w_x_off < c_bd_lo) || (w_x_off >= c_bd_hi) ||
                      (w_y_off < c_bd_lo) || (w_y_off >= c_bd_hi);

  logic [10:0] r_s1_vcount, r_s1_hcount;
  logic        r_s1_vsync, r_s1_vblnk, r_s1_hsync, r_s1_hblnk;
  logic [11:0] r_s1_rgb;
  logic [3:0]  r_s1_col, r_s1_row;
  logic        r_s1_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vcount <= '0;
      r_s1_vsync  <= 1'b0;
      r_s1_vblnk  <= 1'b0;
      r_s1_hcount <= '0;
      r_s1_hsync  <= 1'b0;
      r_s1_hblnk  <= 1'b0;
      r_s1_rgb    <= '0;
      r_s1_col    <= '0;
      r_s1_row    <= '0;
      r_s1_edge   <= 1'b0;
    end else begin
      r_s1_vcount <= vga_in.vcount;
      r_s1_vsync  <= vga_in.vsync;
      r_s1_vblnk  <= vga_in.vblnk;
      r_s1_hcount <= vga_in.hcount;
      r_s1_hsync  <= vga_in.hsync;
      r_s1_hblnk  <= vga_in.hblnk;
      r_s1_rgb    <= vga_in.rgb;
      r_s1_col    <= w_col;
      r_s1_row    <= w_row;
      r_s1_edge   <= w_on_board && w_border;
    end
  end

  logic [11:0] w_rgb;

  always_comb begin
    w_rgb = r_s1_rgb;
    if (!r_s1_vblnk && !r_s1_hblnk && r_s1_edge) begin
      if (r_draw_phase && (r_s1_col == r_draw_col) && (r_s1_row == r_draw_row))
        w_rgb = CURSOR_COLOR;
      else if (r_draw_picked && (r_s1_col == r_draw_fcol) && (r_s1_row == r_draw_frow))
        w_rgb = PICK_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.vcount <= '0;
      vga_out.vsync  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.hcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.vcount <= r_s1_vcount;
      vga_out.vsync  <= r_s1_vsync;
      vga_out.vblnk  <= r_s1_vblnk;
      vga_out.hcount <= r_s1_hcount;
      vga_out.hsync  <= r_s1_hsync;
      vga_out.hblnk  <= r_s1_hblnk;
      vga_out.rgb    <= w_rgb;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_draw_cursor.sv
// ============================================================================
// Module  : tb_draw_cursor
// Brief   : Randomised self-checking bench for draw_cursor with a pixel model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_draw_cursor;

  localparam logic [11:0] CUR  = 12'h0F0;
  localparam logic [11:0] PICK = 12'hF00;
  localparam int BLINK = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic move_up = 1'b0, move_down = 1'b0, move_left = 1'b0, move_right = 1'b0, sel = 1'b0;
  logic [3:0] cur_col, cur_row, from_col, from_row, to_col, to_row;
  logic move_valid;

  always #5 clk = ~clk;

  vga_if vin();
  vga_if vout();

  draw_cursor dut (
    .clk(clk), .rst(rst),
    .move_up(move_up), .move_down(move_down), .move_left(move_left),
    .move_right(move_right), .sel(sel),
    .vga_in(vin), .vga_out(vout),
    .cur_col(cur_col), .cur_row(cur_row), .move_valid(move_valid),
    .from_col(from_col), .from_row(from_row), .to_col(to_col), .to_row(to_row)
  );

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } px_t;

  px_t exq[$];
  int  total = 0;
  int  bad   = 0;

  // Reference state: live cursor/pick and the per-frame snapshot used for drawing
  int m_col, m_row, m_fc, m_fr, m_tc, m_tr, m_frames;
  bit m_picked;
  int d_col, d_row, d_fc, d_fr;
  bit d_picked, d_phase;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model_rgb(input px_t p);
    int x, y, c, r, ox, oy;
    bit brd;
    if (p.hb || p.vb) return p.rgb;
    x = int'(p.h) - 83;
    y = int'(p.v) - 180;
    if (x < 0 || x >= 9 * 45 || y < 0 || y >= 9 * 45) return p.rgb;
    c = x / 45;  ox = x % 45;
    r = y / 45;  oy = y % 45;
    brd = (ox < 3) || (ox >= 42) || (oy < 3) || (oy >= 42);
    if (!brd) return p.rgb;
    if (d_phase && c == d_col && r == d_row) return CUR;
    if (d_picked && c == d_fc && r == d_fr) return PICK;
    return p.rgb;
  endfunction

  function automatic px_t mkpx(input int h, input int v, input logic [11:0] rgb, input logic hb);
    px_t p;
    p.h = 11'(h); p.v = 11'(v);
    p.hs = 1'($urandom_range(0, 1)); p.vs = 1'($urandom_range(0, 1));
    p.hb = hb; p.vb = 1'b0; p.rgb = rgb;
    return p;
  endfunction

  function automatic px_t rand_px();
    px_t p;
    p.h  = 11'($urandom_range(60, 520));
    p.v  = 11'($urandom_range(1, 620));
    p.hs = 1'($urandom_range(0, 1));
    p.vs = 1'($urandom_range(0, 1));
    p.hb = ($urandom_range(0, 9) == 0);
    p.vb = ($urandom_range(0, 9) == 0);
    p.rgb = 12'($urandom);
    return p;
  endfunction

  function automatic logic [31:0] tim_of(input px_t p);
    return {6'd0, p.v, p.vs, p.vb, p.h, p.hs, p.hb};
  endfunction

  task automatic drive_px(input px_t p);
    vin.hcount = p.h; vin.vcount = p.v;
    vin.hsync = p.hs; vin.vsync = p.vs;
    vin.hblnk = p.hb; vin.vblnk = p.vb;
    vin.rgb = p.rgb;
  endtask

  // pl = {up, down, left, right, sel}
  task automatic step(input px_t p, input logic [4:0] pl);
    px_t e, o;
    bit exp_mv;
    drive_px(p);
    {move_up, move_down, move_left, move_right, sel} = pl;
    if (p.v == 11'd0 && p.h == 11'd0) begin
      d_col = m_col; d_row = m_row; d_fc = m_fc; d_fr = m_fr;
      d_picked = m_picked;
      d_phase = ((m_frames / BLINK) % 2) == 0;
      m_frames++;
    end
    e = p;
    e.rgb = model_rgb(p);
    exq.push_back(e);
    exp_mv = 1'b0;
    if (pl[0]) begin
      if (!m_picked) begin
        m_picked = 1'b1; m_fc = m_col; m_fr = m_row;
      end else begin
        m_picked = 1'b0;
        if (m_col != m_fc || m_row != m_fr) begin
          exp_mv = 1'b1; m_tc = m_col; m_tr = m_row;
        end
      end
    end
    if (pl[4])      m_row = (m_row > 0) ? m_row - 1 : 0;
    else if (pl[3]) m_row = (m_row < 8) ? m_row + 1 : 8;
    else if (pl[2]) m_col = (m_col > 0) ? m_col - 1 : 0;
    else if (pl[1]) m_col = (m_col < 8) ? m_col + 1 : 8;
    @(posedge clk);
    #1;
    o = exq.pop_front();
    chk("timing", {6'd0, vout.vcount, vout.vsync, vout.vblnk, vout.hcount, vout.hsync, vout.hblnk},
        tim_of(o));
    chk("rgb", {20'd0, vout.rgb}, {20'd0, o.rgb});
    chk("cursor", {24'd0, cur_col, cur_row}, {24'd0, 4'(m_col), 4'(m_row)});
    chk("move_valid", {31'd0, move_valid}, {31'd0, exp_mv});
    if (exp_mv)
      chk("from_to", {16'd0, from_col, from_row, to_col, to_row},
          {16'd0, 4'(m_fc), 4'(m_fr), 4'(m_tc), 4'(m_tr)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {move_up, move_down, move_left, move_right, sel} = 5'b0;
    drive_px(rand_px());
    repeat (3) @(posedge clk);
    #1;
    chk("rst_timing", {6'd0, vout.vcount, vout.vsync, vout.vblnk, vout.hcount, vout.hsync, vout.hblnk}, 32'd0);
    chk("rst_rgb", {20'd0, vout.rgb}, 32'd0);
    chk("rst_cursor", {24'd0, cur_col, cur_row}, 32'h44);
    chk("rst_move_valid", {31'd0, move_valid}, 32'd0);
    chk("rst_from_to", {16'd0, from_col, from_row, to_col, to_row}, 32'd0);
    m_col = 4; m_row = 4; m_fc = 0; m_fr = 0; m_tc = 0; m_tr = 0;
    m_picked = 1'b0; m_frames = 0;
    d_col = 4; d_row = 4; d_fc = 0; d_fr = 0; d_picked = 1'b0; d_phase = 1'b1;
    exq.delete();
    exq.push_back('0);
    rst = 1'b0;
  endtask

  task automatic mv(input logic [4:0] pl);
    step(rand_px(), pl);
  endtask

  task automatic frame_start();
    step(mkpx(0, 0, 12'($urandom), 1'b0), 5'b0);
  endtask

  localparam logic [4:0] UP = 5'b10000, DN = 5'b01000, LT = 5'b00100, RT = 5'b00010, SL = 5'b00001;

  initial begin
    int pcol;
    logic [4:0] pl;

    // Right-edge saturation
    do_reset();
    repeat (4) mv(RT);
    chk("t1_col8", {28'd0, cur_col}, 32'd8);
    mv(RT);
    chk("t1_sat", {28'd0, cur_col}, 32'd8);

    // Simultaneous pulses and top-edge saturation
    do_reset();
    mv(UP | LT);
    chk("t2_prio", {24'd0, cur_col, cur_row}, 32'h43);
    repeat (3) mv(UP);
    repeat (5) mv(UP);
    chk("t2_row0", {28'd0, cur_row}, 32'd0);

    // Completed move (2,6) -> (4,6)
    do_reset();
    repeat (2) mv(LT);
    repeat (2) mv(DN);
    mv(SL);
    repeat (2) mv(RT);
    mv(SL);
    chk("t3_pulse", {31'd0, move_valid}, 32'd1);
    chk("t3_from_to", {16'd0, from_col, from_row, to_col, to_row}, 32'h2646);
    mv(5'b0);
    chk("t3_single", {31'd0, move_valid}, 32'd0);

    // Cancel at (3,3): no pulse and no pick outline
    mv(LT);
    repeat (3) mv(UP);
    mv(SL);
    mv(SL);
    chk("t4_cancel", {31'd0, move_valid}, 32'd0);
    mv(RT);
    frame_start();
    step(mkpx(218, 315, 12'h321, 1'b0), 5'b0);
    mv(5'b0);
    chk("t4_nopick", {20'd0, vout.rgb}, 32'h321);
    // Pick at (4,3), step away: picked outline appears next frame
    mv(SL);
    mv(RT);
    frame_start();
    step(mkpx(263, 315, 12'h321, 1'b0), 5'b0);
    mv(5'b0);
    chk("t4_pick", {20'd0, vout.rgb}, {20'd0, PICK});

    // Pixel-level overlay with cursor at (0,0)
    do_reset();
    repeat (4) mv(LT);
    repeat (4) mv(UP);
    frame_start();
    step(mkpx(83, 180, 12'h111, 1'b0), 5'b0);
    step(mkpx(85, 180, 12'h222, 1'b0), 5'b0);
    chk("t5_83_180", {20'd0, vout.rgb}, {20'd0, CUR});
    chk("t5_hcount", {21'd0, vout.hcount}, 32'd83);
    step(mkpx(86, 183, 12'h456, 1'b0), 5'b0);
    chk("t5_85_180", {20'd0, vout.rgb}, {20'd0, CUR});
    step(mkpx(83, 180, 12'h789, 1'b1), 5'b0);
    chk("t5_86_183", {20'd0, vout.rgb}, 32'h456);
    mv(5'b0);
    chk("t5_hblnk", {20'd0, vout.rgb}, 32'h789);

    // Blink over 60 frames, mid-frame move deferred to the next frame
    do_reset();
    pcol = 4;
    for (int k = 0; k < 62; k++) begin
      frame_start();
      step(mkpx(83 + pcol * 45, 360, 12'h123, 1'b0), 5'b0);
      mv(5'b0);
      chk("t6_blink", {20'd0, vout.rgb}, ((k % 60) < 30) ? {20'd0, CUR} : 32'h123);
      if (k == 10) begin
        mv(RT);
        step(mkpx(263, 360, 12'h123, 1'b0), 5'b0);
        mv(5'b0);
        chk("t6_old_sq", {20'd0, vout.rgb}, {20'd0, CUR});
        step(mkpx(308, 360, 12'h123, 1'b0), 5'b0);
        mv(5'b0);
        chk("t6_new_sq", {20'd0, vout.rgb}, 32'h123);
        pcol = 5;
      end
    end

    // Random traffic with occasional frame starts and mid-frame resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1000 || i == 2200) do_reset();
      if (i % 150 == 0) begin
        frame_start();
      end else begin
        pl = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 5) == 0)};
        step(rand_px(), pl);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
